// File: rtl/ahb_pkg.sv
// Shared types and constants for the AHB two-master arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } ahb_state_e;

  typedef logic mid_t;

  localparam mid_t MID_M1 = 1'b0;
  localparam mid_t MID_M2 = 1'b1;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/ahb_starve_cnt.sv
// Counts consecutive M2 wins taken while M1 was waiting; forces an M1 win at LIMIT.
module ahb_starve_cnt
  import ahb_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic req_m1,
  input  logic win_m2,
  output logic force_m1
);

  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] cnt_r;

  assign force_m1 = req_m1 && (cnt_r == LIMIT_C);

  // Starvation count: advances only on arbitration edges, saturates at LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 4'd0;
    end else if (arb_en) begin
      if (!req_m1 || !win_m2) begin
        cnt_r <= 4'd0;
      end else if (cnt_r != LIMIT_C) begin
        cnt_r <= cnt_r + 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/ahb_arbiter_ctrl.sv
// Two-master AHB arbiter, M2 over M1, non-overlapped address/data phases.
// Optional starvation guard for M1 enabled by macro AHB_ARB_STARVE_GUARD_EN.
module ahb_arbiter_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic HBUSREQ_M1,
  input  logic HBUSREQ_M2,
  input  logic HREADY,
  output logic HGRANT_M1,
  output logic HGRANT_M2,
  output logic HMASTER,
  output logic HMASTER_D,
  output logic DPHASE_VLD
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  ahb_state_e state_r;
  logic       grant_m1_r;
  logic       grant_m2_r;
  mid_t       hmaster_r;
  mid_t       hmaster_d_r;
  logic       dphase_vld_r;

  logic       any_req_s;
  logic       arb_en_s;
  logic       force_m1_s;
  mid_t       winner_s;

  function automatic mid_t arb_priority(input logic req_m1, input logic req_m2,
                                        input logic force_m1);
    mid_t w;
    if (req_m1 && force_m1) begin
      w = MID_M1;
    end else if (req_m2) begin
      w = MID_M2;
    end else begin
      w = MID_M1;
    end
    return w;
  endfunction

  assign any_req_s = HBUSREQ_M1 | HBUSREQ_M2;
  // Arbitration happens only from IDLE or at the completing edge of DATA.
  assign arb_en_s  = any_req_s && ((state_r == IDLE) || ((state_r == DATA) && HREADY));
  assign winner_s  = arb_priority(HBUSREQ_M1, HBUSREQ_M2, force_m1_s);

`ifdef AHB_ARB_STARVE_GUARD_EN
  ahb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .arb_en  (arb_en_s),
    .req_m1  (HBUSREQ_M1),
    .win_m2  (winner_s == MID_M2),
    .force_m1(force_m1_s)
  );
`else
  assign force_m1_s = 1'b0;
`endif

  // Transfer FSM with all bus-facing outputs registered.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r      <= IDLE;
      grant_m1_r   <= 1'b0;
      grant_m2_r   <= 1'b0;
      hmaster_r    <= MID_M1;
      hmaster_d_r  <= MID_M1;
      dphase_vld_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (arb_en_s) begin
            state_r    <= ADDR;
            grant_m1_r <= (winner_s == MID_M1);
            grant_m2_r <= (winner_s == MID_M2);
            hmaster_r  <= winner_s;
          end else begin
            state_r    <= IDLE;
            grant_m1_r <= 1'b0;
            grant_m2_r <= 1'b0;
          end
        end
        ADDR: begin
          state_r      <= DATA;
          hmaster_d_r  <= hmaster_r;
          dphase_vld_r <= 1'b1;
        end
        DATA: begin
          if (!HREADY) begin
            state_r <= DATA;
          end else if (arb_en_s) begin
            state_r      <= ADDR;
            grant_m1_r   <= (winner_s == MID_M1);
            grant_m2_r   <= (winner_s == MID_M2);
            hmaster_r    <= winner_s;
            dphase_vld_r <= 1'b0;
          end else begin
            state_r      <= IDLE;
            grant_m1_r   <= 1'b0;
            grant_m2_r   <= 1'b0;
            dphase_vld_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          grant_m1_r   <= 1'b0;
          grant_m2_r   <= 1'b0;
          dphase_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign HGRANT_M1  = grant_m1_r;
  assign HGRANT_M2  = grant_m2_r;
  assign HMASTER    = hmaster_r;
  assign HMASTER_D  = hmaster_d_r;
  assign DPHASE_VLD = dphase_vld_r;

endmodule

// File: tb/tb_ahb_arbiter_ctrl.sv
// Self-checking bench for ahb_arbiter_ctrl; output vector is {g1,g2,hmaster,hmaster_d,dphase}.
module tb_ahb_arbiter_ctrl;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic HBUSREQ_M1, HBUSREQ_M2, HREADY;
  logic HGRANT_M1, HGRANT_M2, HMASTER, HMASTER_D, DPHASE_VLD;

  always #5 HCLK = ~HCLK;

  ahb_arbiter_ctrl #(.STARVE_LIMIT(2)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ_M1(HBUSREQ_M1),
    .HBUSREQ_M2(HBUSREQ_M2),
    .HREADY    (HREADY),
    .HGRANT_M1 (HGRANT_M1),
    .HGRANT_M2 (HGRANT_M2),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .DPHASE_VLD(DPHASE_VLD)
  );

  wire [4:0] outs = {HGRANT_M1, HGRANT_M2, HMASTER, HMASTER_D, DPHASE_VLD};

  typedef struct packed {
    logic [4:0]  exp;
    logic [15:0] id;
  } sb_t;

  typedef struct packed {
    logic       r1;
    logic       r2;
    logic       rdy;
    logic [4:0] exp;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[16];
  int   errors = 0;
  int   checks = 0;

  task automatic check_vec(input string what, input int id, input logic [4:0] got,
                           input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s%0d: got %b required %b (g1 g2 hm hmd dv)", what, id, got, exp);
    end
  endtask

  task automatic check_int(input string what, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", what, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input logic a, input logic b, input logic c,
                      input logic [4:0] exp, input int id);
    sb_t e;
    HBUSREQ_M1 = a;
    HBUSREQ_M2 = b;
    HREADY     = c;
    sb_q.push_back('{exp: exp, id: 16'(id)});
    @(posedge HCLK);
    #1;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard%0d: got empty queue required one entry", id);
    end else begin
      e = sb_q.pop_front();
      check_vec("step", int'(e.id), outs, e.exp);
    end
  endtask

  initial begin
    int   n_cyc;
    int   m1_cycles;
    int   dv_cycles;
    logic w;
    logic prev_w;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 5'b10000};  // single M1: ADDR
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'b10001};  // DATA
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'b00000};  // back to IDLE
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 5'b01100};  // M2 ADDR
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'b01111};  // HREADY ignored in ADDR
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 5'b01111};  // wait states, M1 held off
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 5'b01111};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 5'b01111};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 5'b10010};  // M1 only after HREADY
    vecs[10] = '{1'b0, 1'b0, 1'b0, 5'b10001};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 5'b00000};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 5'b01100};  // M2 drops request in ADDR
    vecs[13] = '{1'b0, 1'b0, 1'b1, 5'b01111};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 5'b00110};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 5'b00110};

    HRESETn    = 1'b0;
    HBUSREQ_M1 = 1'b0;
    HBUSREQ_M2 = 1'b0;
    HREADY     = 1'b0;
    #2;
    check_vec("reset", 0, outs, 5'b00000);
    #10;
    HRESETn = 1'b1;
    step(1'b0, 1'b0, 1'b1, 5'b00000, 900);
    step(1'b0, 1'b0, 1'b0, 5'b00000, 901);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].r1, vecs[i].r2, vecs[i].rdy, vecs[i].exp, i);
    end

    // Contention: both requests held, HREADY=1.
`ifdef AHB_ARB_STARVE_GUARD_EN
    n_cyc = 12;
`else
    n_cyc = 10;
`endif
    prev_w    = 1'b1;
    w         = 1'b1;
    m1_cycles = 0;
    dv_cycles = 0;
    for (int k = 0; k < n_cyc; k++) begin
`ifdef AHB_ARB_STARVE_GUARD_EN
      w = ((k / 2) % 3 == 2) ? 1'b0 : 1'b1;
`else
      w = 1'b1;
`endif
      if (k % 2 == 0) begin
        step(1'b1, 1'b1, 1'b1, {~w, w, w, prev_w, 1'b0}, 100 + k);
      end else begin
        step(1'b1, 1'b1, 1'b1, {~w, w, w, w, 1'b1}, 100 + k);
        prev_w = w;
      end
      if (HGRANT_M1) m1_cycles++;
      if (DPHASE_VLD) dv_cycles++;
    end
    step(1'b0, 1'b0, 1'b1, {2'b00, w, w, 1'b0}, 150);
`ifdef AHB_ARB_STARVE_GUARD_EN
    check_int("m1_grant_cycles", m1_cycles, 4);
    check_int("data_phases", dv_cycles, 6);
`else
    check_int("m1_grant_cycles", m1_cycles, 0);
    check_int("data_phases", dv_cycles, 5);
`endif

    // Asynchronous reset during a stalled DATA phase.
    step(1'b0, 1'b1, 1'b1, {2'b01, 1'b1, prev_w, 1'b0}, 200);
    step(1'b0, 1'b0, 1'b0, 5'b01111, 201);
    #3;
    HRESETn = 1'b0;
    #1;
    check_vec("reset_mid_data", 202, outs, 5'b00000);
    #4;
    HRESETn = 1'b1;
    step(1'b0, 1'b0, 1'b1, 5'b00000, 203);
    step(1'b0, 1'b0, 1'b0, 5'b00000, 204);
    step(1'b0, 1'b0, 1'b1, 5'b00000, 205);

    check_int("scoreboard_left", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
